// File: rtl/adc_cond_pkg.sv
// Shared definitions for the ADC conditioning front-end.
//   state_t       : pipeline states of the conditioner FSM
//   midscale()    : 2^(width-1), the offset-binary zero for a given width
//   MIDSCALE_IN   : midscale of the default 12-bit ADC word
//   MIDSCALE_OUT  : midscale of the default 8-bit output sample
package adc_cond_pkg;

  typedef enum logic [1:0] {
    S_ACC,
    S_DC,
    S_SCALE,
    S_LOAD
  } state_t;

  localparam int unsigned DEF_SAMPLE_WIDTH = 12;
  localparam int unsigned DEF_OUT_W        = 8;

  function automatic int unsigned midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  localparam int unsigned MIDSCALE_IN  = midscale(DEF_SAMPLE_WIDTH);
  localparam int unsigned MIDSCALE_OUT = midscale(DEF_OUT_W);

endpackage

// File: rtl/sat_scale.sv
// Combinational gain, rescale, saturate and offset stage.
//   ac     in   SAMPLE_WIDTH+1  signed AC term (mean minus dc estimate)
//   result out  OUT_W           offset-binary sample, midscale = zero
// The AC term is shifted left by GAIN_SHIFT, then arithmetically right by
// SAMPLE_WIDTH-OUT_W (rounds toward -inf), clamped to the signed OUT_W range
// and offset by 2^(OUT_W-1).
module sat_scale #(
  parameter int unsigned SAMPLE_WIDTH = 12,
  parameter int unsigned OUT_W        = 8,
  parameter int unsigned GAIN_SHIFT   = 0
) (
  input  logic signed [SAMPLE_WIDTH:0] ac,
  output logic        [OUT_W-1:0]      result
);

  localparam int unsigned EW   = SAMPLE_WIDTH + 1 + GAIN_SHIFT;
  localparam int unsigned DROP = SAMPLE_WIDTH - OUT_W;
  localparam logic signed [EW-1:0] S_MAX = EW'((1 << (OUT_W - 1)) - 1);
  // ~x == -x-1, so this is the most negative OUT_W value
  localparam logic signed [EW-1:0] S_MIN = ~S_MAX;

  logic signed [EW-1:0]    wide;
  logic signed [EW-1:0]    scaled;
  logic        [OUT_W-1:0] clipped;

  always_comb begin
    wide   = EW'(ac) <<< GAIN_SHIFT;
    scaled = wide >>> DROP;
    if (scaled > S_MAX) begin
      clipped = S_MAX[OUT_W-1:0];
    end else if (scaled < S_MIN) begin
      clipped = S_MIN[OUT_W-1:0];
    end else begin
      clipped = scaled[OUT_W-1:0];
    end
    // adding midscale to an in-range two's complement value flips its MSB
    result = {~clipped[OUT_W-1], clipped[OUT_W-2:0]};
  end

endmodule

// File: rtl/adc_conditioner.sv
// ADC sample front-end feeding the sliding DFT.
//   clk         in   pixel clock
//   reset       in   asynchronous, active-high
//   adc_ready   in   ADC data-valid level; rising edge marks a new word
//   adc_data    in   ADC word, stable while adc_ready is high
//   dc_bypass   in   1: dc fixed at midscale, tracker frozen
//   out_valid   out  out_sample holds an unconsumed result
//   out_ready   in   consumer takes out_sample when out_valid & out_ready
//   out_sample  out  conditioned offset-binary sample
//   overrun     out  sticky: an unconsumed result was overwritten
//   overrun_clr in   clears overrun; a simultaneous new overrun wins
// Boxcar-averages 2^DECIM_LOG2 words, removes DC with a first-order IIR
// tracker, applies gain and saturation, and presents the result on a
// valid/ready hold register three clocks after the completing edge.
module adc_conditioner
  import adc_cond_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int unsigned OUT_W        = DEF_OUT_W,
  parameter int unsigned DECIM_LOG2   = 2,
  parameter int unsigned DC_SHIFT     = 8,
  parameter int unsigned GAIN_SHIFT   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    adc_ready,
  input  logic [SAMPLE_WIDTH-1:0] adc_data,
  input  logic                    dc_bypass,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_sample,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int unsigned AW = SAMPLE_WIDTH + DECIM_LOG2;
  localparam int unsigned CW = DECIM_LOG2 + 1;
  localparam int unsigned DW = SAMPLE_WIDTH + DC_SHIFT;

  localparam logic [CW-1:0]           CNT_LAST = CW'((1 << DECIM_LOG2) - 1);
  localparam logic [SAMPLE_WIDTH-1:0] MID_IN   = SAMPLE_WIDTH'(midscale(SAMPLE_WIDTH));
  localparam logic [OUT_W-1:0]        MID_OUT  = OUT_W'(midscale(OUT_W));
  localparam logic [DW-1:0]           DC_INIT  = DW'(MID_IN) << DC_SHIFT;

  state_t                    state;
  logic                      adc_ready_q;
  logic [AW-1:0]             acc;
  logic [CW-1:0]             cnt;
  logic [SAMPLE_WIDTH-1:0]   mean;
  logic [DW-1:0]             dc_acc;
  logic signed [SAMPLE_WIDTH:0] ac;
  logic [OUT_W-1:0]          result_q;

  logic                      new_word;
  logic [AW-1:0]             sum;
  logic [SAMPLE_WIDTH-1:0]   dc_ref;
  logic signed [SAMPLE_WIDTH:0] ac_next;
  logic [OUT_W-1:0]          scaled;

  always_comb begin
    new_word = adc_ready & ~adc_ready_q;
    sum      = acc + AW'(adc_data);
    dc_ref   = dc_bypass ? MID_IN : dc_acc[DW-1:DC_SHIFT];
    ac_next  = $signed({1'b0, mean}) - $signed({1'b0, dc_ref});
  end

  sat_scale #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .OUT_W        (OUT_W),
    .GAIN_SHIFT   (GAIN_SHIFT)
  ) u_sat_scale (
    .ac     (ac),
    .result (scaled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_ACC;
      adc_ready_q <= 1'b1;
      acc         <= '0;
      cnt         <= '0;
      mean        <= '0;
      dc_acc      <= DC_INIT;
      ac          <= '0;
      result_q    <= MID_OUT;
      out_valid   <= 1'b0;
      out_sample  <= MID_OUT;
      overrun     <= 1'b0;
    end else begin
      adc_ready_q <= adc_ready;

      case (state)
        S_ACC: ;
        S_DC: begin
          ac <= ac_next;
          if (!dc_bypass) begin
            dc_acc <= dc_acc + DW'(ac_next);
          end
          state <= S_SCALE;
        end
        S_SCALE: begin
          result_q <= scaled;
          state    <= S_LOAD;
        end
        S_LOAD: state <= S_ACC;
        default: state <= S_ACC;
      endcase

      // Accumulation runs in every state so words landing while the
      // pipeline drains are not lost; a completing word restarts it.
      if (new_word) begin
        if (cnt == CNT_LAST) begin
          mean  <= SAMPLE_WIDTH'(sum >> DECIM_LOG2);
          acc   <= '0;
          cnt   <= '0;
          state <= S_DC;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end

      if (state == S_LOAD) begin
        out_sample <= result_q;
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if ((state == S_LOAD) && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_conditioner.sv
// Self-checking bench for adc_conditioner. Three instances share stimulus:
//   index 0: DECIM_LOG2=0, GAIN_SHIFT=0
//   index 1: DECIM_LOG2=2, GAIN_SHIFT=0
//   index 2: DECIM_LOG2=0, GAIN_SHIFT=2
module tb_adc_conditioner;
  import adc_cond_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        adc_ready;
  logic [11:0] adc_data;
  logic        dc_bypass;
  logic        out_ready;
  logic        overrun_clr;
  logic [2:0]  ov;
  logic [2:0]  orun;
  logic [7:0]  os [3];

  always #5 clk = ~clk;

  adc_conditioner #(.DECIM_LOG2(0), .GAIN_SHIFT(0)) u_d0 (
    .clk(clk), .reset(reset), .adc_ready(adc_ready), .adc_data(adc_data),
    .dc_bypass(dc_bypass), .out_valid(ov[0]), .out_ready(out_ready),
    .out_sample(os[0]), .overrun(orun[0]), .overrun_clr(overrun_clr));

  adc_conditioner #(.DECIM_LOG2(2), .GAIN_SHIFT(0)) u_d2 (
    .clk(clk), .reset(reset), .adc_ready(adc_ready), .adc_data(adc_data),
    .dc_bypass(dc_bypass), .out_valid(ov[1]), .out_ready(out_ready),
    .out_sample(os[1]), .overrun(orun[1]), .overrun_clr(overrun_clr));

  adc_conditioner #(.DECIM_LOG2(0), .GAIN_SHIFT(2)) u_g2 (
    .clk(clk), .reset(reset), .adc_ready(adc_ready), .adc_data(adc_data),
    .dc_bypass(dc_bypass), .out_valid(ov[2]), .out_ready(out_ready),
    .out_sample(os[2]), .overrun(orun[2]), .overrun_clr(overrun_clr));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_eq(input string name, input int act, input int exp);
    check(act == exp, name, act, exp);
  endtask

  // Reference model: arithmetic on whole outputs, not on clock cycles.
  int dl [3];
  int gl [3];
  int m_sum [3];
  int m_cnt [3];
  int m_dc [3];
  bit exp_v [3];
  int exp_r [3];
  bit obs_v [3];
  int obs_s [3];

  function automatic int fdiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = 0;
      m_cnt[i] = 0;
      m_dc[i]  = int'(MIDSCALE_IN) * 256;
      exp_v[i] = 1'b0;
      exp_r[i] = int'(MIDSCALE_OUT);
    end
  endtask

  task automatic model_word(input int w, input bit byp);
    for (int i = 0; i < 3; i++) begin
      int mean;
      int dc;
      int ac;
      int s;
      m_sum[i] += w;
      m_cnt[i]++;
      exp_v[i] = 1'b0;
      if (m_cnt[i] == (1 << dl[i])) begin
        mean = m_sum[i] / (1 << dl[i]);
        dc   = byp ? int'(MIDSCALE_IN) : m_dc[i] / 256;
        ac   = mean - dc;
        if (!byp) m_dc[i] += ac;
        s = fdiv(ac * (1 << gl[i]), 16);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        exp_v[i] = 1'b1;
        exp_r[i] = s + int'(MIDSCALE_OUT);
        m_sum[i] = 0;
        m_cnt[i] = 0;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("%s_valid_u%0d", tag, i), int'(ov[i]), 0);
      chk_eq($sformatf("%s_sample_u%0d", tag, i), int'(os[i]), int'(MIDSCALE_OUT));
      chk_eq($sformatf("%s_overrun_u%0d", tag, i), int'(orun[i]), 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    adc_ready = 1'b0;
    overrun_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One ADC word: edge at N0, level low at N2, result expected at N4.
  task automatic send(input logic [11:0] w, input bit byp, input bit chk);
    @(negedge clk);
    adc_data  = w;
    dc_bypass = byp;
    adc_ready = 1'b1;
    model_word(int'(w), byp);
    @(negedge clk);
    @(negedge clk);
    adc_ready = 1'b0;
    @(negedge clk);
    if (chk)
      for (int i = 0; i < 3; i++) chk_eq($sformatf("early_valid_u%0d", i), int'(ov[i]), 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      obs_v[i] = ov[i];
      obs_s[i] = int'(os[i]);
    end
    if (chk)
      for (int i = 0; i < 3; i++) begin
        chk_eq($sformatf("valid_u%0d", i), int'(ov[i]), int'(exp_v[i]));
        if (exp_v[i]) chk_eq($sformatf("sample_u%0d", i), int'(os[i]), exp_r[i]);
      end
    @(negedge clk);
    if (chk)
      for (int i = 0; i < 3; i++) begin
        chk_eq($sformatf("consumed_u%0d", i), int'(ov[i]), 0);
        chk_eq($sformatf("held_u%0d", i), int'(os[i]), exp_r[i]);
      end
  endtask

  // Word whose load cycle can be given overrides; returns at N4.
  task automatic raw_word(input logic [11:0] w, input bit clr_at_load, input bit rdy_at_load);
    @(negedge clk);
    adc_data  = w;
    dc_bypass = 1'b1;
    adc_ready = 1'b1;
    model_word(int'(w), 1'b1);
    @(negedge clk);
    @(negedge clk);
    adc_ready = 1'b0;
    @(negedge clk);
    overrun_clr = clr_at_load;
    out_ready   = rdy_at_load;
    @(negedge clk);
    overrun_clr = 1'b0;
  endtask

  typedef struct {
    logic [11:0] word;
    logic [7:0]  exp_d0;
    logic [7:0]  exp_g2;
  } vec_t;

  vec_t tab [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int first;
    int settled;

    tab[0] = '{12'h800, 8'h80, 8'h80};
    tab[1] = '{12'hFFF, 8'hFF, 8'hFF};
    tab[2] = '{12'h000, 8'h00, 8'h00};
    tab[3] = '{12'hC00, 8'hC0, 8'hFF};
    tab[4] = '{12'h400, 8'h40, 8'h00};
    tab[5] = '{12'h810, 8'h81, 8'h84};
    tab[6] = '{12'h7F0, 8'h7F, 8'h7C};
    tab[7] = '{12'h80F, 8'h80, 8'h83};

    dl[0] = 0; dl[1] = 2; dl[2] = 0;
    gl[0] = 0; gl[1] = 0; gl[2] = 2;

    reset = 1'b1;
    adc_ready = 1'b0;
    adc_data = '0;
    dc_bypass = 1'b1;
    out_ready = 1'b1;
    overrun_clr = 1'b0;
    model_reset();
    do_reset();
    check_reset_state("rst");

    // Bypass table: full-scale, zero, rounding and gain saturation.
    for (int k = 0; k < 8; k++) begin
      send(tab[k].word, 1'b1, 1'b1);
      chk_eq($sformatf("tab%0d_d0", k), obs_s[0], int'(tab[k].exp_d0));
      chk_eq($sformatf("tab%0d_g2", k), obs_s[2], int'(tab[k].exp_g2));
    end

    // Four-word boxcar yields one result.
    do_reset();
    nv = 0;
    send(12'h800, 1'b1, 1'b1); nv += int'(obs_v[1]);
    send(12'h800, 1'b1, 1'b1); nv += int'(obs_v[1]);
    send(12'h800, 1'b1, 1'b1); nv += int'(obs_v[1]);
    send(12'h840, 1'b1, 1'b1); nv += int'(obs_v[1]);
    chk_eq("decim_count", nv, 1);
    chk_eq("decim_mean", obs_s[1], 8'h81);

    // Random words, mixed tracking/bypass.
    do_reset();
    for (int k = 0; k < 300; k++)
      send(12'($urandom_range(0, 4095)), ($urandom_range(0, 7) == 0), 1'b1);

    // Overrun handling on the undecimated instance.
    do_reset();
    out_ready = 1'b0;
    send(12'h900, 1'b1, 1'b0);
    chk_eq("ovr_first_valid", int'(ov[0]), 1);
    chk_eq("ovr_first_sample", int'(os[0]), 8'h90);
    chk_eq("ovr_first_flag", int'(orun[0]), 0);
    send(12'hA00, 1'b1, 1'b0);
    chk_eq("ovr_flag", int'(orun[0]), 1);
    chk_eq("ovr_sample", int'(os[0]), 8'hA0);
    chk_eq("ovr_valid", int'(ov[0]), 1);
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    chk_eq("ovr_cleared", int'(orun[0]), 0);
    chk_eq("ovr_valid_kept", int'(ov[0]), 1);
    raw_word(12'hB00, 1'b1, 1'b0);
    chk_eq("ovr_set_wins", int'(orun[0]), 1);
    chk_eq("ovr_set_sample", int'(os[0]), 8'hB0);
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    chk_eq("ovr_cleared2", int'(orun[0]), 0);
    raw_word(12'hC00, 1'b0, 1'b1);
    chk_eq("same_cycle_valid", int'(ov[0]), 1);
    chk_eq("same_cycle_sample", int'(os[0]), 8'hC0);
    chk_eq("same_cycle_no_ovr", int'(orun[0]), 0);
    @(negedge clk);
    chk_eq("same_cycle_consumed", int'(ov[0]), 0);

    // Reset mid-accumulation, with adc_ready high at release.
    do_reset();
    out_ready = 1'b0;
    send(12'h900, 1'b1, 1'b0);
    send(12'h900, 1'b1, 1'b0);
    chk_eq("pre_rst_overrun", int'(orun[0]), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    adc_ready = 1'b1;
    #1 check_reset_state("async_rst");
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk_eq("no_word_at_release", int'(ov[0]), 0);
    adc_ready = 1'b0;
    nv = 0;
    for (int k = 0; k < 4; k++) begin
      send(12'h840, 1'b1, 1'b1);
      nv += int'(obs_v[1]);
    end
    chk_eq("fresh_count", nv, 1);
    chk_eq("fresh_mean", obs_s[1], 8'h84);

    // DC tracking: settle on a constant, then step.
    do_reset();
    for (int k = 0; k < 2000; k++) send(12'h900, 1'b0, 1'b1);
    settled = obs_s[0];
    check(settled == 8'h80 || settled == 8'h7F, "dc_settled", settled, 8'h80);
    send(12'hA00, 1'b0, 1'b1);
    first = obs_s[0];
    check(first == 8'h8F || first == 8'h90, "dc_step", first, 8'h90);
    for (int k = 0; k < 300; k++) send(12'hA00, 1'b0, 1'b1);
    check(obs_s[0] < first && obs_s[0] >= 8'h80, "dc_decay", obs_s[0], first - 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
